seven_seg_arbiter: RTL and testbench

SEVEN_SEG_ARBITER -- requirements
Module: seven_seg_arbiter

---
 rtl/seven_seg_arbiter.sv | 161 ++++++++++++++++
 tb/tb_seven_seg_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_arbiter.sv
// seven_seg_arbiter
//   Two-requester round-robin arbiter in front of a seven-segment display
//   controller. A granted requester owns the display for at least
//   HOLD_CYCLES cycles; during that window only the owner may refresh the
//   value, and each refresh restarts the window. After the window expires
//   the arbiter returns to IDLE and keeps showing the last value.
//
// Parameters
//   HOLD_CYCLES  minimum number of cycles an owner keeps the display (1..2^32-1)
//
// Ports
//   clk_in       sole clock, rising edge
//   rst_in       synchronous active-high reset
//   req0_valid   requester 0 offers req0_val
//   req0_val     requester 0 value (8 hex nibbles)
//   req0_ready   arbiter accepts requester 0 this cycle (combinational)
//   req1_valid   requester 1 offers req1_val
//   req1_val     requester 1 value
//   req1_ready   arbiter accepts requester 1 this cycle (combinational)
//   val_out      registered value for the seven-segment controller
//   owner_out    registered index of the requester that wrote val_out
//   disp_en_out  registered; 0 until the first accepted transfer, then 1
//   update_out   registered one-cycle pulse per accepted transfer
module seven_seg_arbiter #(
  parameter logic [31:0] HOLD_CYCLES = 32'd50_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req0_valid,
  input  logic [31:0] req0_val,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_val,
  output logic        req1_ready,
  output logic [31:0] val_out,
  output logic        owner_out,
  output logic        disp_en_out,
  output logic        update_out
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [31:0] TERM_CNT = HOLD_CYCLES - 32'd1;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] cnt_r;
  logic [31:0] cnt_nxt_s;
  logic        last_r;
  logic        last_nxt_s;
  logic [31:0] val_nxt_s;
  logic        owner_nxt_s;
  logic        disp_en_nxt_s;
  logic        update_nxt_s;
  logic        eff_last_s;
  logic        rdy0_s;
  logic        rdy1_s;
  logic        xfer0_s;
  logic        xfer1_s;

  // Grant decode: owner-only in HOLD, round-robin in IDLE (and while in reset).
  always_comb begin
    rdy0_s     = 1'b0;
    rdy1_s     = 1'b0;
    // Reset presents the IDLE view with the reset value of last, so the
    // handshake seen by requesters is consistent with the post-reset grant.
    eff_last_s = rst_in ? 1'b1 : last_r;
    if ((state_r == ST_HOLD) && !rst_in) begin
      if (owner_out == 1'b0) begin
        rdy0_s = 1'b1;
      end else begin
        rdy1_s = 1'b1;
      end
    end else begin
      case ({req1_valid, req0_valid})
        2'b01:   rdy0_s = 1'b1;
        2'b10:   rdy1_s = 1'b1;
        2'b11: begin
          // Tie goes to the requester that was not granted last.
          if (eff_last_s == 1'b1) begin
            rdy0_s = 1'b1;
          end else begin
            rdy1_s = 1'b1;
          end
        end
        default: begin
          rdy0_s = 1'b0;
          rdy1_s = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = rdy0_s;
  assign req1_ready = rdy1_s;
  assign xfer0_s    = req0_valid & rdy0_s;
  assign xfer1_s    = req1_valid & rdy1_s;

  // Next-state and next-output computation; a transfer outranks hold expiry.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    last_nxt_s    = last_r;
    val_nxt_s     = val_out;
    owner_nxt_s   = owner_out;
    disp_en_nxt_s = disp_en_out;
    update_nxt_s  = 1'b0;
    if (xfer0_s || xfer1_s) begin
      state_nxt_s   = ST_HOLD;
      cnt_nxt_s     = 32'd0;
      last_nxt_s    = xfer1_s;
      owner_nxt_s   = xfer1_s;
      val_nxt_s     = xfer1_s ? req1_val : req0_val;
      disp_en_nxt_s = 1'b1;
      update_nxt_s  = 1'b1;
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (cnt_r == TERM_CNT) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 32'd0;
          end else begin
            cnt_nxt_s = cnt_r + 32'd1;
          end
        end
        ST_IDLE: begin
          cnt_nxt_s = 32'd0;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 32'd0;
        end
      endcase
    end
  end

  // State and output registers; reset discards any same-cycle handshake.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 32'd0;
      last_r      <= 1'b1;
      val_out     <= 32'd0;
      owner_out   <= 1'b0;
      disp_en_out <= 1'b0;
      update_out  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      last_r      <= last_nxt_s;
      val_out     <= val_nxt_s;
      owner_out   <= owner_nxt_s;
      disp_en_out <= disp_en_nxt_s;
      update_out  <= update_nxt_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_arbiter.sv
// tb_seven_seg_arbiter
//   Directed-vector bench for seven_seg_arbiter with HOLD_CYCLES=4, plus a
//   second instance with HOLD_CYCLES=1 for the one-cycle hold boundary.
module tb_seven_seg_arbiter;

  logic        clk_in;
  logic        rst_in;
  logic        rst1_in;
  logic        req0_valid;
  logic [31:0] req0_val;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_val;
  logic        req1_ready;
  logic [31:0] val_out;
  logic        owner_out;
  logic        disp_en_out;
  logic        update_out;

  logic        b_req0_ready;
  logic        b_req1_ready;
  logic [31:0] b_val_out;
  logic        b_owner_out;
  logic        b_disp_en_out;
  logic        b_update_out;

  int checks_r;
  int failures_r;

  seven_seg_arbiter #(.HOLD_CYCLES(32'd4)) u_dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .req0_valid  (req0_valid),
    .req0_val    (req0_val),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_val    (req1_val),
    .req1_ready  (req1_ready),
    .val_out     (val_out),
    .owner_out   (owner_out),
    .disp_en_out (disp_en_out),
    .update_out  (update_out)
  );

  seven_seg_arbiter #(.HOLD_CYCLES(32'd1)) u_dut1 (
    .clk_in      (clk_in),
    .rst_in      (rst1_in),
    .req0_valid  (req0_valid),
    .req0_val    (req0_val),
    .req0_ready  (b_req0_ready),
    .req1_valid  (req1_valid),
    .req1_val    (req1_val),
    .req1_ready  (b_req1_ready),
    .val_out     (b_val_out),
    .owner_out   (b_owner_out),
    .disp_en_out (b_disp_en_out),
    .update_out  (b_update_out)
  );

  // Free-running 10 ns clock.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r = checks_r + 1;
    if (obs !== exp) begin
      failures_r = failures_r + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Stimulus and checks.
  initial begin
    checks_r   = 0;
    failures_r = 0;
    rst_in     = 1'b1;
    rst1_in    = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_val   = 32'h0000_0000;
    req1_val   = 32'h0000_0000;

    // Reset state.
    tick();
    tick();
    check_val("rst_val",    val_out,            32'h0000_0000);
    check_val("rst_owner",  {31'd0, owner_out}, 32'd0);
    check_val("rst_disp",   {31'd0, disp_en_out}, 32'd0);
    check_val("rst_upd",    {31'd0, update_out},  32'd0);

    // Readies during reset follow IDLE rules with last=1; handshake discarded.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_val   = 32'hCAFE_0000;
    req1_val   = 32'hCAFE_0001;
    #1;
    check_val("rst_rdy0_tie", {31'd0, req0_ready}, 32'd1);
    check_val("rst_rdy1_tie", {31'd0, req1_ready}, 32'd0);
    tick();
    check_val("rst_no_xfer_disp", {31'd0, disp_en_out}, 32'd0);
    check_val("rst_no_xfer_val",  val_out, 32'h0000_0000);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_in     = 1'b0;
    #1;
    check_val("idle_none_rdy0", {31'd0, req0_ready}, 32'd0);
    check_val("idle_none_rdy1", {31'd0, req1_ready}, 32'd0);

    // Single transfer from requester 0.
    req0_valid = 1'b1;
    req0_val   = 32'h1234_5678;
    #1;
    check_val("idle_one_rdy0", {31'd0, req0_ready}, 32'd1);
    check_val("idle_one_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_val   = 32'hAAAA_5555;
    #1;
    check_val("x0_val",   val_out, 32'h1234_5678);
    check_val("x0_owner", {31'd0, owner_out},   32'd0);
    check_val("x0_upd",   {31'd0, update_out},  32'd1);
    check_val("x0_disp",  {31'd0, disp_en_out}, 32'd1);

    // Non-owner blocked for the whole 4-cycle hold (counter 0..3).
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("hold_blk_rdy1_c%0d", i), {31'd0, req1_ready}, 32'd0);
      if (i > 0) begin
        check_val($sformatf("hold_upd_low_c%0d", i), {31'd0, update_out}, 32'd0);
      end
      tick();
    end

    // First IDLE cycle: both valid, last=0 so requester 1 wins.
    req0_valid = 1'b1;
    req0_val   = 32'h1111_1111;
    #1;
    check_val("alt_rdy1", {31'd0, req1_ready}, 32'd1);
    check_val("alt_rdy0", {31'd0, req0_ready}, 32'd0);
    tick();
    check_val("x1_val",   val_out, 32'hAAAA_5555);
    check_val("x1_owner", {31'd0, owner_out},  32'd1);
    check_val("x1_upd",   {31'd0, update_out}, 32'd1);
    check_val("x1_hold_rdy0", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Let the hold expire; display keeps its value in IDLE.
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    check_val("idle_keep_val",  val_out, 32'hAAAA_5555);
    check_val("idle_keep_disp", {31'd0, disp_en_out}, 32'd1);
    check_val("idle_keep_upd",  {31'd0, update_out},  32'd0);

    // Tie again, last=1 so requester 0 wins.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_val("alt2_rdy0", {31'd0, req0_ready}, 32'd1);
    check_val("alt2_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    check_val("x2_val",   val_out, 32'h1111_1111);
    check_val("x2_owner", {31'd0, owner_out}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Owner refresh in the terminal-count cycle (counter 0 -> 3).
    tick();
    tick();
    tick();
    req0_valid = 1'b1;
    req0_val   = 32'hDEAD_BEEF;
    #1;
    check_val("refresh_rdy0", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    #1;
    check_val("refresh_val", val_out, 32'hDEAD_BEEF);
    check_val("refresh_upd", {31'd0, update_out}, 32'd1);
    tick();
    tick();
    tick();
    check_val("refresh_ext_rdy1", {31'd0, req1_ready}, 32'd0);
    check_val("refresh_upd_low",  {31'd0, update_out}, 32'd0);
    tick();
    check_val("refresh_end_rdy1", {31'd0, req1_ready}, 32'd1);

    // Fresh req0 grant, then reset mid-hold with req1 valid.
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    req0_val   = 32'h0BAD_F00D;
    tick();
    req0_valid = 1'b0;
    tick();
    check_val("pre_rst_val", val_out, 32'h0BAD_F00D);
    req1_valid = 1'b1;
    rst_in     = 1'b1;
    #1;
    check_val("rst_hold_rdy1", {31'd0, req1_ready}, 32'd1);
    check_val("rst_hold_rdy0", {31'd0, req0_ready}, 32'd0);
    tick();
    rst_in = 1'b0;
    check_val("mid_rst_val",   val_out, 32'h0000_0000);
    check_val("mid_rst_owner", {31'd0, owner_out},   32'd0);
    check_val("mid_rst_disp",  {31'd0, disp_en_out}, 32'd0);
    check_val("mid_rst_upd",   {31'd0, update_out},  32'd0);
    // Tie after reset: last back to 1, requester 0 wins.
    req0_valid = 1'b1;
    req0_val   = 32'h5A5A_A5A5;
    #1;
    check_val("post_rst_rdy0", {31'd0, req0_ready}, 32'd1);
    check_val("post_rst_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    check_val("post_rst_val",   val_out, 32'h5A5A_A5A5);
    check_val("post_rst_owner", {31'd0, owner_out}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // HOLD_CYCLES=1: the hold lasts exactly one cycle.
    rst1_in = 1'b0;
    #1;
    req0_valid = 1'b1;
    req0_val   = 32'h0000_00A1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_val   = 32'h0000_00B2;
    #1;
    check_val("h1_val",      b_val_out, 32'h0000_00A1);
    check_val("h1_upd",      {31'd0, b_update_out}, 32'd1);
    check_val("h1_hold_rdy1", {31'd0, b_req1_ready}, 32'd0);
    req1_valid = 1'b0;
    tick();
    req1_valid = 1'b1;
    #1;
    check_val("h1_idle_rdy1", {31'd0, b_req1_ready}, 32'd1);
    check_val("h1_idle_upd",  {31'd0, b_update_out}, 32'd0);
    tick();
    req1_valid = 1'b0;
    check_val("h1_x1_val",   b_val_out, 32'h0000_00B2);
    check_val("h1_x1_owner", {31'd0, b_owner_out}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
